// File: rtl/elevator_scheduler.sv
// Three-floor elevator call latching and SCAN dispatch controller.
// Latches hall/car calls, picks travel direction, stops the car and times the door.
module elevator_scheduler #(
   parameter int DOOR_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       UP1,
   input  logic       UP2,
   input  logic       DOWN2,
   input  logic       DOWN3,
   input  logic       FLOOR1,
   input  logic       FLOOR2,
   input  logic       FLOOR3,
   input  logic       DC,
   input  logic [1:0] FS,
   output logic       door,
   output logic [1:0] direction,
   output logic [6:0] calls
);

   localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

   localparam logic [6:0] F1_M = 7'b0010001;
   localparam logic [6:0] F2_M = 7'b0100110;
   localparam logic [6:0] F3_M = 7'b1001000;

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR_OPEN
   } state_t;

   state_t     state;
   logic       lastdir;
   logic [7:0] cnt;
   logic [1:0] fs_q;
   logic [1:0] fs_prev;

   logic [6:0] btn;
   logic [6:0] here_m;
   logic [6:0] above_m;
   logic [6:0] below_m;
   logic [6:0] car_m;
   logic [6:0] up_m;
   logic [6:0] dn_m;
   logic [6:0] clr_m;
   logic [6:0] set_m;
   logic       here;
   logic       above;
   logic       below;
   logic       arrive;
   logic       stop_up;
   logic       stop_down;
   logic       same_pend;

   assign btn = {FLOOR3, FLOOR2, FLOOR1, DOWN3, DOWN2, UP2, UP1};

   always_comb begin
      here_m  = '0;
      above_m = '0;
      below_m = '0;
      car_m   = '0;
      up_m    = '0;
      dn_m    = '0;
      case (fs_q)
         2'b01: begin
            here_m  = F1_M;
            above_m = F2_M | F3_M;
            car_m   = 7'b0010000;
            up_m    = 7'b0000001;
         end
         2'b10: begin
            here_m  = F2_M;
            above_m = F3_M;
            below_m = F1_M;
            car_m   = 7'b0100000;
            up_m    = 7'b0000010;
            dn_m    = 7'b0000100;
         end
         2'b11: begin
            here_m  = F3_M;
            below_m = F1_M | F2_M;
            car_m   = 7'b1000000;
            dn_m    = 7'b0001000;
         end
         default: ;
      endcase
   end

   assign here   = |(calls & here_m);
   assign above  = |(calls & above_m);
   assign below  = |(calls & below_m);
   assign arrive = (fs_q != 2'b00) && (fs_q != fs_prev);

   assign stop_up = arrive && ((fs_q == 2'b11) || |(calls & car_m)
                    || |(calls & up_m) || (here && !above));
   assign stop_down = arrive && ((fs_q == 2'b01) || |(calls & car_m)
                      || |(calls & dn_m) || (here && !below));

   // Floor 2 serves the lastdir hall call; if only the opposite one is
   // waiting, that is what opened the door, so it is served instead.
   assign same_pend = lastdir ? calls[1] : calls[2];

   always_comb begin
      clr_m = here_m;
      if (fs_q == 2'b10) begin
         clr_m = 7'b0100000 | (lastdir ? 7'b0000010 : 7'b0000100);
         if (!calls[5] && !same_pend)
            clr_m = clr_m | (lastdir ? 7'b0000100 : 7'b0000010);
      end
   end

   assign set_m = btn & ~((state == DOOR_OPEN) ? here_m : 7'b0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         calls     <= '0;
         lastdir   <= 1'b1;
         cnt       <= '0;
         door      <= 1'b0;
         direction <= 2'b00;
         fs_q      <= 2'b00;
         fs_prev   <= 2'b00;
      end else begin
         fs_q    <= FS;
         fs_prev <= fs_q;
         calls   <= calls | set_m;
         case (state)
            IDLE: begin
               if (here) begin
                  state     <= DOOR_OPEN;
                  door      <= 1'b1;
                  direction <= 2'b00;
                  cnt       <= DOOR_LOAD;
                  calls     <= (calls | set_m) & ~clr_m;
               end else if (above && (lastdir || !below)) begin
                  state     <= MOVE_UP;
                  direction <= 2'b01;
                  lastdir   <= 1'b1;
               end else if (below) begin
                  state     <= MOVE_DOWN;
                  direction <= 2'b10;
                  lastdir   <= 1'b0;
               end
            end
            MOVE_UP, MOVE_DOWN: begin
               if ((state == MOVE_UP) ? stop_up : stop_down) begin
                  state     <= DOOR_OPEN;
                  door      <= 1'b1;
                  direction <= 2'b00;
                  cnt       <= DOOR_LOAD;
                  calls     <= (calls | set_m) & ~clr_m;
               end
            end
            DOOR_OPEN: begin
               if (cnt == 8'd0 || DC) begin
                  state <= IDLE;
                  door  <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: vector table for a full trip
// plus hand sequences for door timing, floor-2 reopen and async reset.
module tb_elevator_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       UP1, UP2, DOWN2, DOWN3, FLOOR1, FLOOR2, FLOOR3, DC;
   logic [1:0] FS;
   logic       door;
   logic [1:0] direction;
   logic [6:0] calls;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [6:0] btn;
      logic       dc;
      logic [1:0] fs;
      logic       exp_door;
      logic [1:0] exp_dir;
      logic [6:0] exp_calls;
   } vec_t;

   vec_t vecs[19];

   elevator_scheduler #(.DOOR_CYCLES(8)) dut (
      .clk(clk),
      .rst(rst),
      .UP1(UP1),
      .UP2(UP2),
      .DOWN2(DOWN2),
      .DOWN3(DOWN3),
      .FLOOR1(FLOOR1),
      .FLOOR2(FLOOR2),
      .FLOOR3(FLOOR3),
      .DC(DC),
      .FS(FS),
      .door(door),
      .direction(direction),
      .calls(calls)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [6:0] b, input logic d,
                        input logic [1:0] f);
      {FLOOR3, FLOOR2, FLOOR1, DOWN3, DOWN2, UP2, UP1} = b;
      DC = d;
      FS = f;
   endtask

   task automatic step(input logic [6:0] b, input logic d,
                       input logic [1:0] f);
      drive(b, d, f);
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic ed,
                      input logic [1:0] edir, input logic [6:0] ec);
      checks++;
      if (door !== ed || direction !== edir || calls !== ec) begin
         errors++;
         $display("FAIL %s: door=%b dir=%b calls=%b, expected door=%b dir=%b calls=%b",
                  name, door, direction, calls, ed, edir, ec);
      end
   endtask

   task automatic do_reset(input logic [1:0] f);
      drive(7'b0, 1'b0, f);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(7'b0, 1'b0, f);
      step(7'b0, 1'b0, f);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{7'b0000000, 1'b0, 2'b01, 1'b0, 2'b00, 7'b0000000};
      vecs[1]  = '{7'b1000000, 1'b0, 2'b01, 1'b0, 2'b00, 7'b1000000};
      vecs[2]  = '{7'b0000000, 1'b0, 2'b01, 1'b0, 2'b01, 7'b1000000};
      vecs[3]  = '{7'b0000000, 1'b0, 2'b00, 1'b0, 2'b01, 7'b1000000};
      vecs[4]  = '{7'b0000000, 1'b0, 2'b00, 1'b0, 2'b01, 7'b1000000};
      vecs[5]  = '{7'b0000000, 1'b0, 2'b10, 1'b0, 2'b01, 7'b1000000};
      vecs[6]  = '{7'b0000000, 1'b0, 2'b10, 1'b0, 2'b01, 7'b1000000};
      vecs[7]  = '{7'b0000000, 1'b1, 2'b00, 1'b0, 2'b01, 7'b1000000};
      vecs[8]  = '{7'b0000000, 1'b0, 2'b11, 1'b0, 2'b01, 7'b1000000};
      for (int i = 9; i <= 16; i++)
         vecs[i] = '{7'b0000000, 1'b0, 2'b11, 1'b1, 2'b00, 7'b0000000};
      vecs[17] = '{7'b0000000, 1'b0, 2'b11, 1'b0, 2'b00, 7'b0000000};
      vecs[18] = '{7'b0000000, 1'b0, 2'b11, 1'b0, 2'b00, 7'b0000000};

      // async reset takes effect with no clock edge
      drive(7'b0, 1'b0, 2'b01);
      rst = 1'b1;
      #2;
      chk("reset_async", 1'b0, 2'b00, 7'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // trip 1 -> 3 on a car call, passing floor 2
      for (int i = 0; i < 19; i++) begin
         step(vecs[i].btn, vecs[i].dc, vecs[i].fs);
         chk($sformatf("trip_vec%0d", i), vecs[i].exp_door,
             vecs[i].exp_dir, vecs[i].exp_calls);
      end

      // UP1 held at floor 1, early close with DC
      do_reset(2'b01);
      step(7'b0000001, 1'b0, 2'b01);
      chk("up1_latched", 1'b0, 2'b00, 7'b0000001);
      step(7'b0000001, 1'b0, 2'b01);
      chk("up1_open_c1", 1'b1, 2'b00, 7'b0000000);
      step(7'b0000001, 1'b0, 2'b01);
      chk("up1_open_c2", 1'b1, 2'b00, 7'b0000000);
      step(7'b0000000, 1'b0, 2'b01);
      chk("up1_open_c3", 1'b1, 2'b00, 7'b0000000);
      step(7'b0000000, 1'b1, 2'b01);
      chk("dc_close", 1'b0, 2'b00, 7'b0000000);
      step(7'b0000000, 1'b0, 2'b01);
      chk("dc_idle", 1'b0, 2'b00, 7'b0000000);

      // up past DOWN2 to floor 3, then down stopping at 2
      step(7'b1000100, 1'b0, 2'b01);
      chk("scan_latch", 1'b0, 2'b00, 7'b1000100);
      step(7'b0000000, 1'b0, 2'b01);
      chk("scan_up", 1'b0, 2'b01, 7'b1000100);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b10);
      step(7'b0000000, 1'b0, 2'b10);
      chk("scan_pass2", 1'b0, 2'b01, 7'b1000100);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b11);
      chk("scan_at3_pre", 1'b0, 2'b01, 7'b1000100);
      step(7'b0000000, 1'b0, 2'b11);
      chk("scan_stop3", 1'b1, 2'b00, 7'b0000100);
      step(7'b0000000, 1'b1, 2'b11);
      chk("scan_close3", 1'b0, 2'b00, 7'b0000100);
      step(7'b0000000, 1'b0, 2'b11);
      chk("scan_down", 1'b0, 2'b10, 7'b0000100);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b10);
      chk("scan_at2_pre", 1'b0, 2'b10, 7'b0000100);
      step(7'b0000000, 1'b0, 2'b10);
      chk("scan_stop2", 1'b1, 2'b00, 7'b0000000);
      step(7'b0000000, 1'b1, 2'b10);
      chk("scan_close2", 1'b0, 2'b00, 7'b0000000);

      // floor 2, lastdir down, both hall calls: serve DOWN2, reopen for UP2
      step(7'b0000110, 1'b0, 2'b10);
      chk("f2_latch", 1'b0, 2'b00, 7'b0000110);
      step(7'b0000000, 1'b0, 2'b10);
      chk("f2_open_dn", 1'b1, 2'b00, 7'b0000010);
      step(7'b0000000, 1'b1, 2'b10);
      chk("f2_close", 1'b0, 2'b00, 7'b0000010);
      step(7'b0000000, 1'b0, 2'b10);
      chk("f2_reopen_up", 1'b1, 2'b00, 7'b0000000);
      step(7'b0000000, 1'b1, 2'b10);
      chk("f2_close2", 1'b0, 2'b00, 7'b0000000);

      // floor 2, lastdir up: tie between FLOOR1 and FLOOR3 goes up
      do_reset(2'b10);
      step(7'b1010000, 1'b0, 2'b10);
      chk("tie_latch", 1'b0, 2'b00, 7'b1010000);
      step(7'b0000000, 1'b0, 2'b10);
      chk("tie_up", 1'b0, 2'b01, 7'b1010000);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b11);
      step(7'b0000000, 1'b0, 2'b11);
      chk("tie_stop3", 1'b1, 2'b00, 7'b0010000);
      step(7'b0000000, 1'b1, 2'b11);
      step(7'b0000000, 1'b0, 2'b11);
      chk("tie_down", 1'b0, 2'b10, 7'b0010000);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b10);
      step(7'b0000000, 1'b0, 2'b10);
      chk("tie_pass2", 1'b0, 2'b10, 7'b0010000);
      step(7'b0000000, 1'b0, 2'b00);
      step(7'b0000000, 1'b0, 2'b01);
      step(7'b0000000, 1'b0, 2'b01);
      chk("tie_stop1", 1'b1, 2'b00, 7'b0000000);

      // reset mid-motion clears everything before the next edge
      do_reset(2'b11);
      step(7'b0110010, 1'b0, 2'b11);
      chk("rst_latch", 1'b0, 2'b00, 7'b0110010);
      step(7'b0000000, 1'b0, 2'b11);
      chk("rst_moving", 1'b0, 2'b10, 7'b0110010);
      rst = 1'b1;
      #1;
      chk("rst_midmotion", 1'b0, 2'b00, 7'b0000000);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(7'b0000000, 1'b0, 2'b11);
      chk("rst_after", 1'b0, 2'b00, 7'b0000000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
